// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the pipeline memory stage and the data
// cache. It turns byte/half/word loads and stores into word cache requests.
// Sub-word stores use a read-modify-write sequence.
// Optional feature macro: LSU_MISALIGN_CHK_EN. When it is defined, misaligned
// H/W accesses complete with o_misaligned=1 and never reach the cache. When it
// is undefined, accesses are forced to natural alignment.
module mem_lsu #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_is_store,
  input  logic [2:0]           i_funct3,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_wdata,
  output logic                 o_valid,
  output logic [DATA_SIZE-1:0] o_rdata,
  output logic                 o_misaligned,
  output logic                 o_req,
  output logic                 o_req_write,
  output logic [ADDR_SIZE-1:0] o_addr,
  output logic [DATA_SIZE-1:0] o_store_data,
  input  logic                 i_req_ready,
  input  logic                 i_data_valid,
  input  logic [DATA_SIZE-1:0] i_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  // Size is funct3[1:0]: 00 byte, 01 half, anything else is a word.
  // funct3[2] selects zero-extension for loads.

  // Pick the addressed lane out of a cache word and extend it.
  function automatic logic [31:0] f_extend(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3[1:0])
      2'b00: begin
        if (funct3[2]) res = {24'd0, b};
        else           res = {{24{b[7]}}, b};
      end
      2'b01: begin
        if (funct3[2]) res = {16'd0, h};
        else           res = {{16{h[15]}}, h};
      end
      default: res = word;
    endcase
    return res;
  endfunction

  // Insert the low byte/half of the store data into the addressed lane of
  // the old cache word, keeping the other lanes.
  function automatic logic [31:0] f_merge(input logic [31:0] old,
                                          input logic [31:0] wdata,
                                          input logic [1:0]  off,
                                          input logic [2:0]  funct3);
    logic [31:0] res;
    res = old;
    case (funct3[1:0])
      2'b00: begin
        case (off)
          2'b00:   res[7:0]   = wdata[7:0];
          2'b01:   res[15:8]  = wdata[7:0];
          2'b10:   res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) res[31:16] = wdata[15:0];
        else        res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

`ifdef LSU_MISALIGN_CHK_EN
  // An access is misaligned if a half has addr[0] set or a word has a non-zero byte offset.
  function automatic logic f_misaligned(input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic res;
    case (funct3[1:0])
      2'b00:   res = 1'b0;
      2'b01:   res = off[0];
      default: res = (off != 2'b00);
    endcase
    return res;
  endfunction
`endif

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [2:0]           r_funct3;
  logic                 r_is_store;
  logic [DATA_SIZE-1:0] r_rdata;
  logic [DATA_SIZE-1:0] r_store_data;
  logic                 w_accept;
  logic                 w_is_word;
  logic                 w_misaligned;

  assign w_accept  = i_valid && (r_state == S_IDLE);
  assign w_is_word = i_funct3[1];

`ifdef LSU_MISALIGN_CHK_EN
  logic r_misaligned;
  assign w_misaligned = f_misaligned(i_funct3, i_addr[1:0]);
  assign o_misaligned = r_misaligned;
`else
  assign w_misaligned = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Request/handshake outputs decode from the state register only.
  assign o_ready      = (r_state == S_IDLE);
  assign o_valid      = (r_state == S_RESP);
  assign o_req        = (r_state == S_RD) || (r_state == S_WR);
  assign o_req_write  = (r_state == S_WR);
  assign o_addr       = {r_addr[ADDR_SIZE-1:2], 2'b00};
  assign o_store_data = r_store_data;
  assign o_rdata      = r_rdata;

  // Next-state decode for the single-op access sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          if (w_misaligned)                w_state_nxt = S_RESP;
          else if (i_is_store && w_is_word) w_state_nxt = S_WR;
          else                             w_state_nxt = S_RD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (i_req_ready) w_state_nxt = S_RD_WAIT;
        else             w_state_nxt = S_RD;
      end
      S_RD_WAIT: begin
        if (i_data_valid) begin
          if (r_is_store) w_state_nxt = S_WR;
          else            w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_WR: begin
        if (i_req_ready) w_state_nxt = S_WR_WAIT;
        else             w_state_nxt = S_WR;
      end
      S_WR_WAIT: begin
        if (i_data_valid) w_state_nxt = S_RESP;
        else              w_state_nxt = S_WR_WAIT;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset abandons any op in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Operand capture on acceptance, then load extraction or store merge on the read response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr       <= '0;
      r_funct3     <= 3'd0;
      r_is_store   <= 1'b0;
      r_rdata      <= '0;
      r_store_data <= '0;
`ifdef LSU_MISALIGN_CHK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr       <= i_addr;
            r_funct3     <= i_funct3;
            r_is_store   <= i_is_store;
            r_rdata      <= '0;
            // Holds the raw store data until a sub-word merge replaces it.
            r_store_data <= i_wdata;
`ifdef LSU_MISALIGN_CHK_EN
            r_misaligned <= w_misaligned;
`endif
          end
        end
        S_RD_WAIT: begin
          if (i_data_valid) begin
            if (r_is_store)
              r_store_data <= f_merge(i_data, r_store_data, r_addr[1:0], r_funct3);
            else
              r_rdata <= f_extend(i_data, r_addr[1:0], r_funct3);
          end
        end
        S_RESP: begin
`ifdef LSU_MISALIGN_CHK_EN
          r_misaligned <= 1'b0;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule
